// File: rtl/mult_issue_pkg.sv
// rtl/mult_issue_pkg.sv - shared types and default constants for the multiplier issue stage
package mult_issue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_DEF        = 32;
    localparam int DEPTH_DEF    = 4;
    localparam int MULT_LAT_DEF = 36;

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// rtl/mult_issue_ctrl_if.sv - operand, multiplier and product handshake bundle
interface mult_issue_ctrl_if
    import mult_issue_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [N-1:0]             in_a;
    logic [N-1:0]             in_b;
    logic [N-1:0]             mult_a;
    logic [N-1:0]             mult_b;
    logic                     mult_start;
    logic [2*N-1:0]           mult_result;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*N-1:0]           out_result;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_count;

    // Issue controller side
    modport slave (
        input  in_valid, in_a, in_b, mult_result, out_ready,
        output in_ready, mult_a, mult_b, mult_start, out_valid, out_result, busy, fifo_count
    );

    // Producer / multiplier / consumer side
    modport master (
        output in_valid, in_a, in_b, mult_result, out_ready,
        input  in_ready, mult_a, mult_b, mult_start, out_valid, out_result, busy, fifo_count
    );

endinterface

// File: rtl/op_fifo.sv
// rtl/op_fifo.sv - synchronous operand-pair FIFO with occupancy count
module op_fifo
    import mult_issue_pkg::*;
#(
    parameter int W     = 2 * N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            wdata,
    output logic [W-1:0]            rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array; contents are don't-care until written, so no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - buffers operand pairs and sequences them through the fixed-latency multiplier
module mult_issue_ctrl
    import mult_issue_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    mult_issue_ctrl_if.slave   bus
);

    localparam int CW = $clog2(MULT_LAT + 1);

    state_t                   state;
    logic [CW-1:0]            lat_cnt;
    logic [N-1:0]             a_q;
    logic [N-1:0]             b_q;
    logic                     start_q;
    logic                     out_valid_q;
    logic [2*N-1:0]           out_result_q;

    logic [2*N-1:0]           head;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     push;
    logic                     pop;

    // Accept only on free space; a same-cycle pop does not open a slot
    assign push = bus.in_valid && !full;
    assign pop  = (state == IDLE) && !empty;

    op_fifo #(
        .W     (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.in_a, bus.in_b}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.in_ready   = !full;
    assign bus.fifo_count = count;
    assign bus.mult_a     = a_q;
    assign bus.mult_b     = b_q;
    assign bus.mult_start = start_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.busy       = (state != IDLE);

    // Issue sequencer: pop, pulse start, wait out the latency, hold the product until taken
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            start_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {a_q, b_q} <= head;
                        start_q    <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    lat_cnt <= CW'(MULT_LAT - 1);
                    state   <= RUN;
                end
                RUN: begin
                    if (lat_cnt == '0) begin
                        out_result_q <= bus.mult_result;
                        out_valid_q  <= 1'b1;
                        state        <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb/tb_mult_issue_ctrl.sv - self-checking bench for mult_issue_ctrl with a behavioural multiplier
module tb_mult_issue_ctrl;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 36;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    int   checks = 0;
    int   errors = 0;

    logic [63:0] exp_q [$];
    int          hs_q [$];
    int          hs_total = 0;
    int          start_count = 0;
    int          dbl_start = 0;
    int          stab_viol = 0;
    bit          last_start = 0;
    bit          prev_ok = 0;
    logic [31:0] pa, pb;

    logic [63:0] m_prod;
    int          m_cnt = 0;
    bit          m_act = 0;

    mult_issue_ctrl_if #(.N(N), .DEPTH(DEPTH)) bus ();

    mult_issue_ctrl #(.N(N), .DEPTH(DEPTH), .MULT_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multiplier model: product becomes valid LAT cycles after the start cycle, garbage before
    always @(negedge clk) begin
        if (!reset) begin
            m_act = 0;
        end else if (bus.mult_start) begin
            m_prod = 64'(bus.mult_a) * 64'(bus.mult_b);
            m_cnt  = 0;
            m_act  = 1;
        end else if (m_act && m_cnt < LAT) begin
            m_cnt++;
        end
        bus.mult_result = (m_act && m_cnt >= LAT && !bus.mult_start) ? m_prod : {$urandom, $urandom};
    end

    // Scoreboard and protocol monitor
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset) begin
            exp_q.delete();
            prev_ok    = 0;
            last_start = 0;
        end else begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(64'(bus.in_a) * 64'(bus.in_b));
            if (bus.out_valid && bus.out_ready) begin
                hs_q.push_back(cyc);
                hs_total++;
                check("out_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_result", 128'(bus.out_result), 128'(e));
                end
            end
            if (bus.mult_start) start_count++;
            if (bus.mult_start && last_start) dbl_start++;
            last_start = bus.mult_start;
            if (prev_ok && !bus.mult_start && (bus.mult_a !== pa || bus.mult_b !== pb))
                stab_viol++;
            pa      = bus.mult_a;
            pb      = bus.mult_b;
            prev_ok = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, output int pc);
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        pc           = -1000;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
            if (ok) begin
                pc = cyc;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max, output int at);
        at = -1000;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int pc, at, s, bad, k, first_drop, cnt_full, pushed, hs_base, guard;
        bit ok;
        logic [63:0] r;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();

        check("rst_in_ready",   128'(bus.in_ready),   128'(1));
        check("rst_fifo_count", 128'(bus.fifo_count), 128'(0));
        check("rst_busy",       128'(bus.busy),       128'(0));
        check("rst_out_valid",  128'(bus.out_valid),  128'(0));
        check("rst_out_result", 128'(bus.out_result), 128'(0));
        check("rst_mult_ab",    128'({bus.mult_a, bus.mult_b}), 128'(0));
        check("rst_mult_start", 128'(bus.mult_start), 128'(0));
        reset = 1'b1;
        step();

        // Reset while the multiplier is running abandons the pair
        bus.out_ready = 1'b1;
        push(32'd3, 32'd5, pc);
        repeat (9) step();
        check("mid_busy_before_rst", 128'(bus.busy), 128'(1));
        reset = 1'b0;
        step();
        check("mid_rst_fifo_count", 128'(bus.fifo_count), 128'(0));
        check("mid_rst_busy",       128'(bus.busy),       128'(0));
        check("mid_rst_in_ready",   128'(bus.in_ready),   128'(1));
        reset = 1'b1;
        bad = 0;
        s = start_count;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        step();
        check("mid_rst_no_output", 128'(bad), 128'(0));
        check("mid_rst_no_start",  128'(start_count - s), 128'(0));

        // Single operation latency and result
        s = start_count;
        push(32'd7, 32'd9, pc);
        wait_out(80, at);
        check("single_latency", 128'(at - pc), 128'(LAT + 2));
        check("single_result",  128'(bus.out_result), 128'(63));
        check("single_starts",  128'(start_count - s), 128'(1));
        repeat (3) step();

        // Maximum operands, held under backpressure for a few cycles
        bus.out_ready = 1'b0;
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, pc);
        wait_out(80, at);
        check("max_result", 128'(bus.out_result), 128'(64'hFFFF_FFFE_0000_0001));
        check("max_mult_a", 128'(bus.mult_a), 128'(32'hFFFF_FFFF));
        repeat (4) step();
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("max_idle", 128'(bus.busy), 128'(0));

        // Fill the FIFO back-to-back and measure throughput
        hs_q.delete();
        k = 0;
        first_drop = -1;
        cnt_full = -1;
        for (int g = 0; g < 100 && k < 6; g++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'(k + 1);
            bus.in_b     = 32'(k + 100);
            @(negedge clk);
            if (!bus.in_ready && first_drop < 0) begin
                first_drop = k;
                cnt_full   = int'(bus.fifo_count);
            end
            ok = bus.in_ready;
            step();
            if (ok) k++;
        end
        bus.in_valid = 1'b0;
        check("fill_first_drop", 128'(first_drop), 128'(5));
        check("fill_count_full", 128'(cnt_full), 128'(DEPTH));
        for (int i = 0; i < 400 && hs_q.size() < 6; i++) step();
        check("fill_outputs", 128'(hs_q.size()), 128'(6));
        for (int i = 1; i < 6 && i < hs_q.size(); i++)
            check("fill_period", 128'(hs_q[i] - hs_q[i-1]), 128'(LAT + 3));
        repeat (3) step();

        // Backpressure: product holds and the queued pair waits for the handshake
        bus.out_ready = 1'b0;
        push(32'd11, 32'd13, pc);
        push(32'd17, 32'd19, pc);
        wait_out(80, at);
        s = start_count;
        r = bus.out_result;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_result !== r) bad++;
        end
        check("bp_hold",        128'(bad), 128'(0));
        check("bp_held_value",  128'(r), 128'(64'd143));
        check("bp_no_start",    128'(start_count - s), 128'(0));
        check("bp_fifo_count",  128'(bus.fifo_count), 128'(1));
        check("bp_mult_a",      128'(bus.mult_a), 128'(32'd11));
        step();
        bus.out_ready = 1'b1;
        step();
        check("bp_start_after_hs", 128'(start_count - s), 128'(0));
        wait_out(80, at);
        check("bp_second_start",  128'(start_count - s), 128'(1));
        check("bp_second_result", 128'(bus.out_result), 128'(64'd323));
        repeat (3) step();

        // Randomized traffic with random consumer backpressure
        hs_base = hs_total;
        pushed = 0;
        guard = 0;
        while (pushed < 30 && guard < 4000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_a      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus.in_b      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus.out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) pushed++;
            step();
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || bus.busy); i++) step();
        check("rand_pushed",   128'(pushed), 128'(30));
        check("rand_outputs",  128'(hs_total - hs_base), 128'(30));
        check("rand_drained",  128'(exp_q.size()), 128'(0));
        check("final_idle",    128'(bus.busy), 128'(0));
        check("operand_stable", 128'(stab_viol), 128'(0));
        check("start_one_cycle", 128'(dbl_start), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
Upstream issue stage for the 32-bit sequential multiplier. Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. Presents one pair at a time to the multiplier, holding it stable, and restarts the multiplier with a one-cycle start pulse. Counts the multiplier's fixed latency, captures the 2N-bit product and offers it downstream over a valid/ready handshake.

Parameters:
N, 32, operand width; product is 2*N
DEPTH, 4, operand FIFO entries (power of 2, >=2)
MULT_LAT, 36, cycles from the mult_start cycle until mult_result is valid (input reg + N iterations + output reg, plus margin)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept; equals !full
in_a  in  N  multiplicand
in_b  in  N  multiplier
mult_a  out  N  held operand A to the multiplier
mult_b  out  N  held operand B to the multiplier
mult_start  out  1  one-cycle pulse; multiplier clears and restarts on it
mult_result  in  2N  multiplier product
out_valid  out  1  product available
out_ready  in  1  consumer accepts
out_result  out  2N  captured product
busy  out  1  FSM not in IDLE
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset==0 at a clk edge): FIFO emptied, fifo_count=0, in_ready=1 on the next cycle, mult_a=mult_b=0, mult_start=0, out_valid=0, out_result=0, busy=0, state=IDLE, latency counter=0. Reset mid-operation abandons the in-flight pair and any queued pairs; nothing is emitted.
- FIFO push: in_valid & in_ready. in_ready=!full only, so no push happens when full, even if a pop occurs that cycle. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH. Empty pop is impossible because the FSM pops only when count>0.
- FSM states:
  - IDLE: if count>0, pop the head into mult_a/mult_b, go to START. Otherwise stay.
  - START: mult_start=1 for exactly this cycle. Load the counter with MULT_LAT-1, go to RUN.
  - RUN: decrement the counter. When counter==0, capture mult_result into out_result, set out_valid=1, go to DONE.
  - DONE: hold out_valid and out_result until out_valid & out_ready, then clear out_valid and go to IDLE.
- mult_a/mult_b are stable from the pop until the next pop. They are never changed during START, RUN or DONE.
- Latency: the first pair pushed into an empty idle block appears on out_valid MULT_LAT+2 cycles after the push edge. Sustained throughput is one product per MULT_LAT+3 cycles with out_ready held at 1.
- out_result is the full unsigned 2N-bit value from mult_result, with no truncation or sign handling.
- The FIFO keeps accepting while the FSM is in RUN or DONE, up to DEPTH entries.
- busy = (state != IDLE).

Decomposition:
- Package mult_issue_pkg holds:
  - state enum IDLE/START/RUN/DONE as a 2-bit encoding
  - default constants N_DEF=32, DEPTH_DEF=4, MULT_LAT_DEF=36
- Sub-module op_fifo: a synchronous 2N-bit wide, DEPTH-deep FIFO with push/pop/full/empty/count.
- The FSM, latency counter and output register live in the top module.

Test Plan:
- Reset mid-RUN: push (3,5), assert reset=0 for 1 cycle at cycle 10 -> out_valid never rises; fifo_count=0, busy=0, in_ready=1.
- Single op, bench multiplier model with MULT_LAT=36: push a=7, b=9 -> mult_start pulses once; out_valid rises 38 cycles after the push with out_result=63.
- Max operands: push a=b=0xFFFFFFFF -> out_result=0xFFFFFFFE00000001. mult_a/mult_b stay constant from pop through the DONE handshake.
- Fill FIFO: push 6 pairs back-to-back with out_ready=1 -> in_ready drops after 5 pushes (4 queued + 1 popped). Products emerge in push order, one per 39 cycles.
- Backpressure: out_ready=0 for 100 cycles after out_valid -> out_valid and out_result hold steady. No new mult_start occurs; a second queued pair issues only after the handshake.
